cc_branch_resolver: RTL and testbench
=====================================

# cc_branch_resolver

Condition-code register and branch resolver at the consumer end of the `setcc` flag path. It latches the C/Z/N/V flags that `setcc` produces on add/sub/cmp operations. It accepts branch requests through a valid/ready handshake, evaluates a 4-bit condition against the current flags, and returns a registered taken/not-taken result with the selected next PC to the fetch stage.

## Interface
Parameters:
- `WIDTH`, default 32: PC / target address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flag_we`  in  1  flag update strobe from `setcc` (asserted on add/sub/cmp).
- `c_in`, `z_in`, `n_in`, `v_in`  in  1 each  flags from `setcc`.
- `br_valid`  in  1  branch request valid.
- `br_ready`  out  1  resolver can accept a request.
- `br_cond`  in  4  condition code, encoding listed under Operation.
- `br_target`  in  WIDTH  branch target address.
- `br_pc_next`  in  WIDTH  fall-through PC.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_taken`  out  1  condition evaluated true.
- `res_pc`  out  WIDTH  `br_target` if taken, else `br_pc_next`.
- `flags`  out  4  architectural flags, ordered {C,Z,N,V}.

## Operation
- Flag register: when `flag_we`=1, load {c_in,z_in,n_in,v_in} at the clock edge; otherwise hold.
- Condition encoding:
  - 0 AL = 1; 1 EQ = Z; 2 NE = !Z; 3 CS = C; 4 CC = !C; 5 MI = N; 6 PL = !N; 7 VS = V; 8 VC = !V.
  - 9 HI = C&!Z; 10 LS = !C|Z; 11 GE = (N==V); 12 LT = (N!=V); 13 GT = !Z&(N==V); 14 LE = Z|(N!=V); 15 NV = 0.
- Output FSM with two states:
  - EMPTY (`res_valid`=0): goes to FULL on accept (`br_valid & br_ready`).
  - FULL (`res_valid`=1): returns to EMPTY when `res_ready`=1 and no new accept; stays FULL with the new result when `res_ready`=1 and a new request is accepted in the same cycle; holds when `res_ready`=0.
- `br_ready` = !`res_valid` | `res_ready`. The CC_BYPASS_EN rule below adds a further restriction.
- `res_taken`, `res_pc` and `res_valid` are registered. `res_taken` and `res_pc` are stable while `res_valid`=1 and `res_ready`=0.
- Width rules: `res_pc` is a pure mux, no arithmetic. `br_cond` is fully decoded, so there are no illegal codes.

## Timing
- Latency: request accepted in cycle T; result is visible with `res_valid`=1 in cycle T+1.
- Throughput: one branch per cycle when `res_ready` is held at 1.
- Flags written at edge T are used by any branch accepted in cycle T+1 or later.
- Simultaneous `flag_we` and accept in the same cycle: behaviour depends on CC_BYPASS_EN (see Configuration).
- Reset, at any time including mid-handshake:
  - `res_valid`=0, `res_taken`=0, `res_pc`=0, flags=4'b0000.
  - Any pending result is discarded.
  - `br_ready`=1 immediately once `rst_n` is released.

## Configuration
- `CC_BYPASS_EN` defined: a branch accepted in the same cycle as `flag_we` evaluates the incoming `c_in`/`z_in`/`n_in`/`v_in`, not the registered flags. `br_ready` does not depend on `flag_we`.
- `CC_BYPASS_EN` undefined: `br_ready` is forced to 0 in any cycle with `flag_we`=1. The branch is accepted the following cycle, once the flags are registered. This adds one cycle of latency for back-to-back cmp/branch pairs.

## Structure
- Shared package `cc_pkg` contains:
  - condition-code localparams `CC_AL` … `CC_NV`;
  - flag bit-index constants `CC_C`=3, `CC_Z`=2, `CC_N`=1, `CC_V`=0;
  - the FSM state encoding.
- One sub-module, `cc_eval`: a combinational function of (cond, flags) producing `taken`. It is reusable by other decode logic.
- The top level holds the flag register, the output FSM, the result registers, and the bypass mux.

## Test plan
- Reset then idle: after `rst_n` is released, `res_valid`=0, `flags`=0, `br_ready`=1. A request with `br_cond`=AL, target 0x100, next 0x004 gives `res_taken`=1 and `res_pc`=0x100 one cycle later.
- Flags from a cmp (C=0, Z=1, N=0, V=0) are written. Next-cycle results:
  - EQ gives taken, `res_pc`=target.
  - NE gives not taken, `res_pc`=0x004.
  - GE gives taken; LT gives not taken.
- Signed compare with N=1, V=0: LT taken, GE not taken, LE taken, GT not taken. HI with C=1, Z=0 is taken; NV is never taken.
- Backpressure: hold `res_ready`=0 for 3 cycles with `res_valid`=1. Required: `br_ready`=0, and `res_pc`/`res_taken` unchanged. When `res_ready` rises, the queued request is accepted in the same cycle.
- Same-cycle `flag_we` (Z=1) with an EQ request while the old Z was 0:
  - With CC_BYPASS_EN: accepted that cycle, result taken.
  - Without it: `br_ready`=0 that cycle; accepted next cycle, result taken one cycle later.
- Assert `rst_n`=0 while `res_valid`=1 and `res_ready`=0. Required: outputs and flags clear asynchronously with no clock edge, and no stale result appears after release.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code path: condition encodings, flag bit positions
// and the result FSM state type.
package cc_pkg;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_EQ = 4'd1;
  localparam logic [3:0] CC_NE = 4'd2;
  localparam logic [3:0] CC_CS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_MI = 4'd5;
  localparam logic [3:0] CC_PL = 4'd6;
  localparam logic [3:0] CC_VS = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_HI = 4'd9;
  localparam logic [3:0] CC_LS = 4'd10;
  localparam logic [3:0] CC_GE = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GT = 4'd13;
  localparam logic [3:0] CC_LE = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Bit positions within the {C,Z,N,V} flag vector.
  localparam int unsigned CC_C = 3;
  localparam int unsigned CC_Z = 2;
  localparam int unsigned CC_N = 1;
  localparam int unsigned CC_V = 0;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } res_state_e;

endpackage

// File: rtl/cc_eval.sv
// Combinational condition evaluator: decides whether a 4-bit condition holds for a
// {C,Z,N,V} flag vector.
module cc_eval
  import cc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);

  logic c, z, n, v;

  assign c = flags_i[CC_C];
  assign z = flags_i[CC_Z];
  assign n = flags_i[CC_N];
  assign v = flags_i[CC_V];

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      CC_AL: taken_o = 1'b1;
      CC_EQ: taken_o = z;
      CC_NE: taken_o = !z;
      CC_CS: taken_o = c;
      CC_CC: taken_o = !c;
      CC_MI: taken_o = n;
      CC_PL: taken_o = !n;
      CC_VS: taken_o = v;
      CC_VC: taken_o = !v;
      CC_HI: taken_o = c & !z;
      CC_LS: taken_o = !c | z;
      CC_GE: taken_o = (n == v);
      CC_LT: taken_o = (n != v);
      CC_GT: taken_o = !z & (n == v);
      CC_LE: taken_o = z | (n != v);
      CC_NV: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_branch_resolver.sv
// Flag register plus branch resolver with a one-entry registered result stage.
// Define CC_BYPASS_EN to let a branch see flags written in the same cycle.
module cc_branch_resolver
  import cc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             c_in,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             v_in,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] br_pc_next,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [WIDTH-1:0] res_pc,
  output logic [3:0]       flags
);

  res_state_e       state_d, state_q;
  logic [3:0]       flags_d, flags_q;
  logic             res_taken_d, res_taken_q;
  logic [WIDTH-1:0] res_pc_d, res_pc_q;
  logic [3:0]       flags_in, eval_flags;
  logic             accept, taken;

  assign flags_in = {c_in, z_in, n_in, v_in};

`ifdef CC_BYPASS_EN
  assign br_ready   = !res_valid | res_ready;
  assign eval_flags = flag_we ? flags_in : flags_q;
`else
  // Stall the branch for a cycle so it sees the flags once they are registered.
  assign br_ready   = (!res_valid | res_ready) & !flag_we;
  assign eval_flags = flags_q;
`endif

  assign accept = br_valid & br_ready;

  cc_eval u_eval (
    .cond_i  (br_cond),
    .flags_i (eval_flags),
    .taken_o (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      flags_q     <= 4'b0000;
      res_taken_q <= 1'b0;
      res_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      res_taken_q <= res_taken_d;
      res_pc_q    <= res_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (res_ready && !accept) state_d = StEmpty;
    endcase
  end

  always_comb begin
    flags_d     = flag_we ? flags_in : flags_q;
    res_taken_d = res_taken_q;
    res_pc_d    = res_pc_q;
    if (accept) begin
      res_taken_d = taken;
      res_pc_d    = taken ? br_target : br_pc_next;
    end
  end

  always_comb begin
    res_valid = (state_q == StFull);
    res_taken = res_taken_q;
    res_pc    = res_pc_q;
    flags     = flags_q;
  end

endmodule

// File: tb/tb_cc_branch_resolver.sv
// Self-checking bench for cc_branch_resolver: directed steps then random traffic checked
// against a cycle-level reference model.
module tb_cc_branch_resolver;

  localparam int W = 32;
`ifdef CC_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flag_we = 1'b0, c_in = 1'b0, z_in = 1'b0, n_in = 1'b0, v_in = 1'b0;
  logic         br_valid = 1'b0, res_ready = 1'b0;
  logic         br_ready, res_valid, res_taken;
  logic [3:0]   br_cond = 4'd0;
  logic [W-1:0] br_target = '0, br_pc_next = '0;
  logic [W-1:0] res_pc;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  cc_branch_resolver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_we    (flag_we),
    .c_in       (c_in),
    .z_in       (z_in),
    .n_in       (n_in),
    .v_in       (v_in),
    .br_valid   (br_valid),
    .br_ready   (br_ready),
    .br_cond    (br_cond),
    .br_target  (br_target),
    .br_pc_next (br_pc_next),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_taken  (res_taken),
    .res_pc     (res_pc),
    .flags      (flags)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit [3:0]   m_flags = 4'b0;
  bit         m_valid = 1'b0;
  bit         m_taken = 1'b0;
  bit [W-1:0] m_pc = '0;

  function automatic bit ref_eval(input int cond, input bit [3:0] f);
    bit c, z, n, v, signed_ge, unsigned_hi;
    c = f[3]; z = f[2]; n = f[1]; v = f[0];
    signed_ge   = (n == v);
    unsigned_hi = c && !z;
    case (cond)
      0:  return 1'b1;
      1:  return z;
      2:  return !z;
      3:  return c;
      4:  return !c;
      5:  return n;
      6:  return !n;
      7:  return v;
      8:  return !v;
      9:  return unsigned_hi;
      10: return !unsigned_hi;
      11: return signed_ge;
      12: return !signed_ge;
      13: return signed_ge && !z;
      14: return !(signed_ge && !z);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ready();
    return (!m_valid || res_ready) && !(!Bypass && flag_we);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit fw, input bit [3:0] f, input bit bv, input int cond,
                        input bit [W-1:0] tgt, input bit [W-1:0] nxt, input bit rr);
    flag_we    = fw;
    {c_in, z_in, n_in, v_in} = f;
    br_valid   = bv;
    br_cond    = 4'(cond);
    br_target  = tgt;
    br_pc_next = nxt;
    res_ready  = rr;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    bit acc;
    bit [3:0] eff;
    #1;
    check("br_ready", br_ready, m_ready());
    acc = br_valid && m_ready();
    eff = (Bypass && flag_we) ? {c_in, z_in, n_in, v_in} : m_flags;
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_taken = ref_eval(int'(br_cond), eff);
      m_pc    = m_taken ? br_target : br_pc_next;
    end else if (res_ready) begin
      m_valid = 1'b0;
    end
    if (flag_we) m_flags = {c_in, z_in, n_in, v_in};
    #1;
    check("res_valid", res_valid, m_valid);
    check("res_taken", res_taken, m_taken);
    check("res_pc", res_pc, m_pc);
    check("flags", flags, m_flags);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_flags = 4'b0; m_valid = 1'b0; m_taken = 1'b0; m_pc = '0;
  endtask

  initial begin
    // Reset values while held in reset
    #2;
    check("rst_valid", res_valid, 1'b0);
    check("rst_flags", flags, 4'b0);
    check("rst_pc", res_pc, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready", br_ready, 1'b1);

    // AL branch
    set_in(0, 4'b0, 1, 0, 32'h100, 32'h004, 1); tick();
    check("al_pc", res_pc, 32'h100);
    check("al_taken", res_taken, 1'b1);

    // cmp flags C=0 Z=1 N=0 V=0, then EQ/NE/GE/LT
    set_in(1, 4'b0100, 0, 0, 0, 0, 1); tick();
    set_in(0, 4'b0, 1, 1, 32'h200, 32'h004, 1); tick();
    check("eq_pc", res_pc, 32'h200);
    set_in(0, 4'b0, 1, 2, 32'h200, 32'h004, 1); tick();
    check("ne_pc", res_pc, 32'h004);
    set_in(0, 4'b0, 1, 11, 32'h300, 32'h004, 1); tick();
    set_in(0, 4'b0, 1, 12, 32'h300, 32'h004, 1); tick();

    // N=1 V=0, C=1 Z=0
    set_in(1, 4'b1010, 0, 0, 0, 0, 1); tick();
    for (int k = 0; k < 6; k++) begin
      int conds[6] = '{12, 11, 14, 13, 9, 15};
      set_in(0, 4'b0, 1, conds[k], 32'h400 + 32'(k), 32'h008, 1); tick();
    end
    check("nv_taken", res_taken, 1'b0);

    // Backpressure: result held for 3 cycles, queued request waits
    set_in(0, 4'b0, 1, 0, 32'hAAA0, 32'h10, 1); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 4'b0, 1, 15, 32'hBBB0, 32'h20, 0); tick();
      check("bp_pc", res_pc, 32'hAAA0);
    end
    set_in(0, 4'b0, 1, 15, 32'hBBB0, 32'h20, 1); tick();
    check("bp_drain_pc", res_pc, 32'h20);

    // Same-cycle flag write (Z=1) with EQ while old Z=0
    set_in(1, 4'b0000, 0, 0, 0, 0, 1); tick();
    set_in(1, 4'b0100, 1, 1, 32'hC00, 32'h30, 1); tick();
    set_in(0, 4'b0, Bypass ? 1'b0 : 1'b1, 1, 32'hC00, 32'h30, 1); tick();
    check("same_cycle_taken", res_taken, 1'b1);
    check("same_cycle_pc", res_pc, 32'hC00);

    // Async reset mid-handshake
    set_in(1, 4'b1111, 1, 0, 32'hDEAD, 32'h40, 1); tick();
    set_in(0, 4'b0, 1, 0, 32'hBEEF, 32'h44, 0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", res_valid, 1'b0);
    check("arst_taken", res_taken, 1'b0);
    check("arst_pc", res_pc, '0);
    check("arst_flags", flags, 4'b0);
    set_in(0, 4'b0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_no_stale", res_valid, 1'b0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 15)), W'($urandom), W'($urandom), $urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
